// File: rtl/bus_arbiter_pkg.sv
// Shared bus package.
// Holds the arbiter state encoding, the default bus geometry, and the
// one-hot-to-index encoder used by the arbiter and by the bus units.
package bus_arbiter_pkg;

  localparam int DEF_N_UNITS = 4;
  localparam int DEF_SEL_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

  // Encodes a one-hot (or all-zero) vector of up to 16 bits into its index.
  // An all-zero vector encodes to 0, matching the idle bus select.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      idx = idx | (oh[i] ? 4'(i) : 4'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_checker.sv
// bus_arbiter_checker: property checks on the arbiter outputs.
// Ports: clk, rstn and the four arbiter outputs, observed only.
module bus_arbiter_checker
  import bus_arbiter_pkg::*;
#(
  parameter int N_UNITS = DEF_N_UNITS,
  parameter int SEL_W   = DEF_SEL_W
) (
  input logic               clk,
  input logic               rstn,
  input logic [N_UNITS-1:0] grant,
  input logic [SEL_W-1:0]   bus_sel,
  input logic               bus_busy,
  input logic               timeout
);

  logic [15:0] grant_ext_s;
  assign grant_ext_s = 16'(grant);

  a_onehot: assert property (@(posedge clk) disable iff (!rstn)
    $onehot0(grant));

  a_busy: assert property (@(posedge clk) disable iff (!rstn)
    bus_busy == (|grant));

  a_sel: assert property (@(posedge clk) disable iff (!rstn)
    4'(bus_sel) == onehot_to_idx(grant_ext_s));

  a_timeout_idle: assert property (@(posedge clk) disable iff (!rstn)
    timeout |-> (grant == '0));

  // Once the bus goes idle it stays idle for at least one more cycle.
  a_gap: assert property (@(posedge clk) disable iff (!rstn)
    bus_busy ##1 !bus_busy |=> !bus_busy);

endmodule

// File: rtl/bus_arbiter_rr_picker.sv
// rr_picker: purely combinational round-robin winner search.
// Ports:
//   req    - one request bit per unit
//   ptr    - index of the most recent winner; the search starts at ptr+1
//   winner - index of the first set request bit at or after ptr+1 (wrapping)
//   found  - high when any request bit is set
module rr_picker
  import bus_arbiter_pkg::*;
#(
  parameter int N_UNITS = DEF_N_UNITS,
  parameter int SEL_W   = DEF_SEL_W
) (
  input  logic [N_UNITS-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               found
);

  logic [SEL_W-1:0] hi_idx_s;
  logic [SEL_W-1:0] lo_idx_s;
  logic             hi_any_s;

  // Split search: lowest requester above ptr wins; otherwise wrap to the
  // lowest requester at or below ptr. Descending loop leaves the lowest
  // index as the final assignment.
  always_comb begin
    hi_idx_s = '0;
    lo_idx_s = '0;
    hi_any_s = 1'b0;
    for (int i = N_UNITS - 1; i >= 0; i--) begin
      hi_idx_s = (req[i] && (i > int'(ptr)))  ? SEL_W'(i) : hi_idx_s;
      lo_idx_s = (req[i] && (i <= int'(ptr))) ? SEL_W'(i) : lo_idx_s;
      hi_any_s = hi_any_s | (req[i] && (i > int'(ptr)));
    end
  end

  assign winner = hi_any_s ? hi_idx_s : lo_idx_s;
  assign found  = |req;

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner selector for the shared tri-state bus.
// A tenure ends on release or after MAX_HOLD grant cycles, and is always
// followed by one TURN cycle and one IDLE cycle with no grant so that two
// units never drive the bus together.
// Ports:
//   clk, rstn - clock and asynchronous active-low reset
//   req       - level request per unit
//   grant     - registered one-hot grant (or zero)
//   bus_sel   - encoded owner index, 0 when idle
//   bus_busy  - high when grant is non-zero
//   timeout   - one-cycle pulse on the first TURN cycle after a forced end
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_UNITS  = DEF_N_UNITS,
  parameter int SEL_W    = DEF_SEL_W,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_UNITS-1:0] req,
  output logic [N_UNITS-1:0] grant,
  output logic [SEL_W-1:0]   bus_sel,
  output logic               bus_busy,
  output logic               timeout
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX_V = HOLD_W'(MAX_HOLD);
  localparam logic [SEL_W-1:0]   PTR_RST    = SEL_W'(N_UNITS - 1);
  localparam logic [N_UNITS-1:0] ONE_HOT0   = N_UNITS'(1);

  arb_state_e         state_r, state_nxt_s;
  logic [HOLD_W-1:0]  hold_r, hold_nxt_s;
  logic [SEL_W-1:0]   ptr_r, ptr_nxt_s;
  logic [N_UNITS-1:0] grant_r, grant_nxt_s;
  logic [SEL_W-1:0]   bus_sel_r, bus_sel_nxt_s;
  logic               bus_busy_r, bus_busy_nxt_s;
  logic               timeout_r, timeout_nxt_s;

  logic [SEL_W-1:0]   winner_s;
  logic               found_s;
  logic               owner_req_s;
  logic               expired_s;

  rr_picker #(
    .N_UNITS (N_UNITS),
    .SEL_W   (SEL_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_r),
    .winner (winner_s),
    .found  (found_s)
  );

  // bus_sel_r holds the owner index for the whole GRANT state.
  assign owner_req_s = req[bus_sel_r];
  assign expired_s   = (hold_r == HOLD_MAX_V);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; release takes priority over expiry.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) state_nxt_s = ST_GRANT;
        else         state_nxt_s = ST_IDLE;
      end
      ST_GRANT: begin
        if (!owner_req_s || expired_s) state_nxt_s = ST_TURN;
        else                           state_nxt_s = ST_GRANT;
      end
      ST_TURN: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, hold counter and pointer.
  always_comb begin
    grant_nxt_s    = '0;
    bus_sel_nxt_s  = '0;
    bus_busy_nxt_s = 1'b0;
    timeout_nxt_s  = 1'b0;
    hold_nxt_s     = '0;
    ptr_nxt_s      = ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          ptr_nxt_s      = winner_s;
          grant_nxt_s    = ONE_HOT0 << winner_s;
          bus_sel_nxt_s  = winner_s;
          bus_busy_nxt_s = 1'b1;
          hold_nxt_s     = HOLD_ONE;
        end else begin
          ptr_nxt_s      = ptr_r;
        end
      end
      ST_GRANT: begin
        if (!owner_req_s) begin
          timeout_nxt_s  = 1'b0;
        end else if (expired_s) begin
          timeout_nxt_s  = 1'b1;
        end else begin
          grant_nxt_s    = grant_r;
          bus_sel_nxt_s  = bus_sel_r;
          bus_busy_nxt_s = 1'b1;
          hold_nxt_s     = hold_r + HOLD_ONE;
        end
      end
      ST_TURN: begin
        grant_nxt_s = '0;
      end
      default: begin
        ptr_nxt_s = PTR_RST;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_r     <= '0;
      ptr_r      <= PTR_RST;
      grant_r    <= '0;
      bus_sel_r  <= '0;
      bus_busy_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      hold_r     <= hold_nxt_s;
      ptr_r      <= ptr_nxt_s;
      grant_r    <= grant_nxt_s;
      bus_sel_r  <= bus_sel_nxt_s;
      bus_busy_r <= bus_busy_nxt_s;
      timeout_r  <= timeout_nxt_s;
    end
  end

  assign grant    = grant_r;
  assign bus_sel  = bus_sel_r;
  assign bus_busy = bus_busy_r;
  assign timeout  = timeout_r;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] bus_sel;
  logic       bus_busy;
  logic       timeout;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.N_UNITS(4), .SEL_W(2), .MAX_HOLD(4)) dut (
    .clk(clk), .rstn(rstn), .req(req), .grant(grant),
    .bus_sel(bus_sel), .bus_busy(bus_busy), .timeout(timeout)
  );

  bus_arbiter_checker #(.N_UNITS(4), .SEL_W(2)) u_chk (
    .clk(clk), .rstn(rstn), .grant(grant),
    .bus_sel(bus_sel), .bus_busy(bus_busy), .timeout(timeout)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] sel_of(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Drive req for one edge and queue the outputs expected after that edge.
  task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic eto);
    exp_t e;
    req = r;
    @(posedge clk);
    #1;
    e.grant   = eg;
    e.sel     = sel_of(eg);
    e.busy    = |eg;
    e.timeout = eto;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs with the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("grant",    8'(grant),    8'(mon_e.grant));
      check("bus_sel",  8'(bus_sel),  8'(mon_e.sel));
      check("bus_busy", 8'(bus_busy), 8'(mon_e.busy));
      check("timeout",  8'(timeout),  8'(mon_e.timeout));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    req  = 4'b0000;
    // Reset state.
    step(4'b1111, 4'b0000, 1'b0);
    step(4'b1111, 4'b0000, 1'b0);
    rstn = 1'b1;

    // Round-robin order with timeouts: unit 0 first out of reset.
    for (int u = 0; u < 4; u++) begin
      for (int k = 0; k < 4; k++) step(4'b1111, 4'b0001 << u, 1'b0);
      step(4'b1111, 4'b0000, 1'b1);
      step(4'b1111, 4'b0000, 1'b0);
    end
    for (int k = 0; k < 4; k++) step(4'b1111, 4'b0001, 1'b0);
    // Release on the very edge the hold limit is reached: no timeout.
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // Voluntary release by unit 1 after two cycles.
    step(4'b0010, 4'b0010, 1'b0);
    step(4'b0010, 4'b0010, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // Sole preempted requester keeps regaining the bus.
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < 4; k++) step(4'b0100, 4'b0100, 1'b0);
      step(4'b0100, 4'b0000, 1'b1);
      step(4'b0100, 4'b0000, 1'b0);
    end
    step(4'b0100, 4'b0100, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // Late arrival during TURN: unit 3 waits for the IDLE edge.
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b1000, 4'b0000, 1'b0);
    step(4'b1000, 4'b1000, 1'b0);
    // Another requester does not shorten unit 3's tenure.
    step(4'b1010, 4'b1000, 1'b0);
    step(4'b1010, 4'b1000, 1'b0);
    step(4'b0010, 4'b0000, 1'b0);
    step(4'b0010, 4'b0000, 1'b0);
    step(4'b0010, 4'b0010, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // Reset mid-tenure of unit 2.
    step(4'b0100, 4'b0100, 1'b0);
    step(4'b0100, 4'b0100, 1'b0);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("rst_grant",   8'(grant),    8'h00);
    check("rst_bus_sel", 8'(bus_sel),  8'h00);
    check("rst_busy",    8'(bus_busy), 8'h00);
    step(4'b0001, 4'b0000, 1'b0);
    rstn = 1'b1;
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
